// File: rtl/clock_gate_ctrl.sv
// Idle-detect controller driving the enable of one clock-gating cell.
// Gates after a run of idle cycles, wakes on activity with a settle period.
module clock_gate_ctrl #(
  parameter int IDLE_THRESHOLD = 16,
  parameter int WAKE_CYCLES    = 2,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_enable,
  input  logic             busy,
  input  logic             force_on,
  input  logic             wake_req,
  output logic             gate_en,
  output logic             wake_ack,
  output logic             is_gated,
  output logic [CNT_W-1:0] gate_events
);

  localparam int IW = $clog2(IDLE_THRESHOLD + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [IW-1:0] TH_M1 = IW'(IDLE_THRESHOLD - 1);
  localparam logic [WW-1:0] WK_M1 = WW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_ACTIVE,
    S_IDLE,
    S_GATED,
    S_WAKING
  } state_t;

  state_t            r_state;
  state_t            w_nstate;
  logic [IW-1:0]     r_idle_cnt;
  logic [IW-1:0]     w_idle_nxt;
  logic [WW-1:0]     r_wake_cnt;
  logic [WW-1:0]     w_wake_nxt;
  logic              r_gate_en;
  logic              r_is_gated;
  logic              r_ack;
  logic              r_acked;
  logic [CNT_W-1:0]  r_events;
  logic              w_idle_ok;
  logic              w_pend;
  logic              w_ack_nxt;
  logic              w_enter_g;

  assign w_idle_ok = cfg_enable & ~busy & ~force_on & ~wake_req;
  assign w_pend    = wake_req & ~r_acked;
  assign w_enter_g = (w_nstate == S_GATED) && (r_state != S_GATED);

  always_comb begin
    w_nstate   = r_state;
    w_idle_nxt = r_idle_cnt;
    w_wake_nxt = r_wake_cnt;
    w_ack_nxt  = 1'b0;
    unique case (r_state)
      S_ACTIVE: begin
        w_ack_nxt = w_pend;
        if (w_idle_ok) begin
          if (IDLE_THRESHOLD == 1) begin
            w_nstate = S_GATED;
          end else begin
            w_nstate   = S_IDLE;
            w_idle_nxt = IW'(1);
          end
        end
      end
      S_IDLE: begin
        w_ack_nxt = w_pend;
        if (!w_idle_ok) begin
          w_nstate   = S_ACTIVE;
          w_idle_nxt = '0;
        end else if (r_idle_cnt == TH_M1) begin
          w_nstate   = S_GATED;
          w_idle_nxt = '0;
        end else begin
          w_idle_nxt = r_idle_cnt + 1'b1;
        end
      end
      S_GATED: begin
        if (!w_idle_ok) begin
          w_nstate   = S_WAKING;
          w_wake_nxt = '0;
        end
      end
      S_WAKING: begin
        // inputs deliberately ignored until the settle period ends
        if (r_wake_cnt == WK_M1) begin
          w_nstate = S_ACTIVE;
        end else begin
          w_wake_nxt = r_wake_cnt + 1'b1;
        end
      end
      default: w_nstate = S_ACTIVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_ACTIVE;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_gate_en  <= 1'b1;
      r_is_gated <= 1'b0;
      r_ack      <= 1'b0;
      r_acked    <= 1'b0;
      r_events   <= '0;
    end else begin
      r_state    <= w_nstate;
      r_idle_cnt <= w_idle_nxt;
      r_wake_cnt <= w_wake_nxt;
      r_gate_en  <= (w_nstate != S_GATED);
      r_is_gated <= (w_nstate == S_GATED);
      r_ack      <= w_ack_nxt;
      // one ack per request; rearmed once wake_req is seen low
      r_acked    <= wake_req & (r_acked | w_ack_nxt);
      if (w_enter_g && (r_events != '1)) begin
        r_events <= r_events + 1'b1;
      end
    end
  end

  assign gate_en     = r_gate_en;
  assign wake_ack    = r_ack;
  assign is_gated    = r_is_gated;
  assign gate_events = r_events;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Bench for clock_gate_ctrl: default instance plus a small-parameter one.
// Hand sequences, a vector table, and random stimulus against a model.
module tb_clock_gate_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cfg_enable, busy, force_on, wake_req;
  logic        gate_en, wake_ack, is_gated;
  logic [15:0] gate_events;

  logic        rst_nb, cfg_b, busy_b, force_b, wake_b;
  logic        ge_b, ack_b, ig_b;
  logic [1:0]  ev_b;

  clock_gate_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_enable (cfg_enable),
    .busy       (busy),
    .force_on   (force_on),
    .wake_req   (wake_req),
    .gate_en    (gate_en),
    .wake_ack   (wake_ack),
    .is_gated   (is_gated),
    .gate_events(gate_events)
  );

  clock_gate_ctrl #(
    .IDLE_THRESHOLD(1),
    .WAKE_CYCLES   (1),
    .CNT_W         (2)
  ) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_nb),
    .cfg_enable (cfg_b),
    .busy       (busy_b),
    .force_on   (force_b),
    .wake_req   (wake_b),
    .gate_en    (ge_b),
    .wake_ack   (ack_b),
    .is_gated   (ig_b),
    .gate_events(ev_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       busy;
    logic       wake;
    logic       ge;
    logic       ack;
    logic       ig;
    logic [1:0] ev;
  } vec_t;

  vec_t tbl[18];

  bit m_gated, m_acked, m_ack;
  int m_wleft, m_run, m_ev;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string nm, input logic ge, input logic ack,
                       input logic ig, input int ev);
    chk({nm, ".gate_en"}, 32'(gate_en), 32'(ge));
    chk({nm, ".wake_ack"}, 32'(wake_ack), 32'(ack));
    chk({nm, ".is_gated"}, 32'(is_gated), 32'(ig));
    chk({nm, ".events"}, 32'(gate_events), 32'(ev));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic c, input logic b, input logic f,
                       input logic w);
    cfg_enable = c;
    busy       = b;
    force_on   = f;
    wake_req   = w;
  endtask

  // Behavioural view: an idle run length, a gated flag, a settle countdown.
  task automatic model_reset();
    m_gated = 0; m_acked = 0; m_ack = 0;
    m_wleft = 0; m_run = 0; m_ev = 0;
  endtask

  task automatic model_step(input logic c, input logic b, input logic f,
                            input logic w);
    bit ok;
    ok    = c & ~b & ~f & ~w;
    m_ack = 0;
    if (m_gated) begin
      if (!ok) begin
        m_gated = 0;
        m_wleft = 2;
      end
    end else if (m_wleft > 0) begin
      m_wleft--;
    end else begin
      if (w && !m_acked) begin
        m_ack   = 1;
        m_acked = 1;
      end
      m_run = ok ? m_run + 1 : 0;
      if (m_run >= 16) begin
        m_gated = 1;
        m_run   = 0;
        if (m_ev < 65535) m_ev++;
      end
    end
    if (!w) m_acked = 0;
  endtask

  initial begin
    tbl = '{
      '{0, 0, 0, 0, 1, 1},
      '{1, 0, 1, 0, 0, 1},
      '{1, 0, 1, 0, 0, 1},
      '{0, 0, 0, 0, 1, 2},
      '{1, 0, 1, 0, 0, 2},
      '{0, 0, 1, 0, 0, 2},
      '{0, 0, 0, 0, 1, 3},
      '{1, 0, 1, 0, 0, 3},
      '{1, 0, 1, 0, 0, 3},
      '{0, 0, 0, 0, 1, 3},
      '{1, 0, 1, 0, 0, 3},
      '{0, 0, 1, 0, 0, 3},
      '{0, 0, 0, 0, 1, 3},
      '{0, 1, 1, 0, 0, 3},
      '{0, 1, 1, 0, 0, 3},
      '{0, 1, 1, 1, 0, 3},
      '{0, 1, 1, 0, 0, 3},
      '{0, 0, 0, 0, 1, 3}
    };

    rst_n = 1; rst_nb = 1;
    set_a(1, 1, 1, 1);
    cfg_b = 1; busy_b = 1; force_b = 0; wake_b = 0;
    #2;
    rst_n = 0; rst_nb = 0;
    #1;
    chk_a("rst0", 1, 0, 0, 0);

    // idle run to threshold
    @(negedge clk);
    set_a(1, 0, 0, 0);
    rst_n = 1;
    repeat (15) tick();
    chk_a("idle15", 1, 0, 0, 0);
    tick();
    chk_a("idle16", 0, 0, 1, 1);

    // wake request handshake
    wake_req = 1;
    tick(); chk_a("wk_e1", 1, 0, 0, 1);
    tick(); chk_a("wk_e2", 1, 0, 0, 1);
    tick(); chk_a("wk_e3", 1, 0, 0, 1);
    tick(); chk_a("wk_ack", 1, 1, 0, 1);
    tick(); chk_a("wk_post", 1, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      tick(); chk_a("wk_hold", 1, 0, 0, 1);
    end
    wake_req = 0;
    tick(); chk_a("wk_drop", 1, 0, 0, 1);
    wake_req = 1;
    tick(); chk_a("wk_ack2", 1, 1, 0, 1);
    tick(); chk_a("wk_ack2p", 1, 0, 0, 1);

    // interrupted idle run restarts the count
    wake_req = 0;
    repeat (15) tick();
    busy = 1;
    tick();
    busy = 0;
    repeat (15) tick();
    chk_a("brk31", 1, 0, 0, 1);
    tick();
    chk_a("brk32", 0, 0, 1, 2);

    // force_on and cfg_enable hold the clock running
    force_on = 1;
    tick(); chk_a("frc_wake", 1, 0, 0, 2);
    for (int i = 0; i < 100; i++) begin
      tick(); chk_a("frc_hold", 1, 0, 0, 2);
    end
    force_on = 0;
    repeat (16) tick();
    chk_a("frc_regate", 0, 0, 1, 3);
    cfg_enable = 0;
    tick(); chk_a("cfg_wake", 1, 0, 0, 3);
    for (int i = 0; i < 100; i++) begin
      tick(); chk_a("cfg_hold", 1, 0, 0, 3);
    end
    cfg_enable = 1;
    repeat (16) tick();
    chk_a("regate4", 0, 0, 1, 4);

    // asynchronous reset mid-cycle while gated
    #2;
    set_a(0, 1, 1, 1);
    rst_n = 0;
    #1;
    chk_a("rst_mid", 1, 0, 0, 0);

    // small instance: saturation table
    @(negedge clk);
    rst_nb = 1;
    for (int i = 0; i < 18; i++) begin
      busy_b = tbl[i].busy;
      wake_b = tbl[i].wake;
      tick();
      chk($sformatf("tbl%0d.ge", i), 32'(ge_b), 32'(tbl[i].ge));
      chk($sformatf("tbl%0d.ack", i), 32'(ack_b), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d.ig", i), 32'(ig_b), 32'(tbl[i].ig));
      chk($sformatf("tbl%0d.ev", i), 32'(ev_b), 32'(tbl[i].ev));
    end
    #2;
    rst_nb = 0;
    #1;
    chk("b_rst.ge", 32'(ge_b), 32'd1);
    chk("b_rst.ev", 32'(ev_b), 32'd0);
    chk("b_rst.ig", 32'(ig_b), 32'd0);

    // random stimulus against the model
    @(negedge clk);
    set_a(1, 0, 0, 0);
    model_reset();
    rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      cfg_enable = ($urandom_range(0, 31) != 0);
      busy       = (i % 200 < 100) ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 39) == 0);
      force_on   = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 19) == 0) wake_req = ~wake_req;
      model_step(cfg_enable, busy, force_on, wake_req);
      tick();
      chk_a("rand", !m_gated, m_ack, m_gated, m_ev);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
